// File: rtl/reg_context_mover.sv
// reg_context_mover: context save/restore engine. Streams a full register
// bank snapshot to memory (save) or fills a shadow buffer from memory and
// hands it to the register file with a single-cycle Load_Proc strobe (load).
module reg_context_mover #(
    parameter int NUM_REGS = 64,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Save_Req,
    input  logic                       Load_Req,
    input  logic [ADDR_W-1:0]          Ctx_Base,
    input  logic [NUM_REGS*DATA_W-1:0] Save_Data,
    output logic [NUM_REGS*DATA_W-1:0] Load_Data,
    output logic                       Load_Proc,
    output logic [ADDR_W-1:0]          Mem_Addr,
    output logic [DATA_W-1:0]          Mem_Write_Data,
    output logic                       Mem_Write,
    output logic                       Mem_Read,
    input  logic [DATA_W-1:0]          Mem_Read_Data,
    input  logic                       Mem_Ack,
    output logic                       Busy,
    output logic                       Done
);

    localparam int BUS_W = NUM_REGS * DATA_W;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_LOAD,
        S_COMMIT,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [BUS_W-1:0]   snap_q, snap_d;
    logic [BUS_W-1:0]   buf_q, buf_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic               lp_q, lp_d;
    logic               done_q, done_d;

    // State and datapath registers; reset aborts any transfer and drops the
    // partially filled buffer so it can never be committed.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            snap_q  <= '0;
            buf_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            lp_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            snap_q  <= snap_d;
            buf_q   <= buf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            lp_q    <= lp_d;
            done_q  <= done_d;
        end
    end

    // Next-state, beat sequencing and buffer updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        snap_d  = snap_q;
        buf_d   = buf_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                // Save has priority; a coincident load is dropped.
                if (Save_Req) begin
                    state_d = S_SAVE;
                    snap_d  = Save_Data;
                    base_d  = Ctx_Base;
                    idx_d   = '0;
                end else if (Load_Req) begin
                    state_d = S_LOAD;
                    base_d  = Ctx_Base;
                    idx_d   = '0;
                end
            end
            S_SAVE: begin
                // Request low only in the first cycle of the state: the
                // final beat leaves the state on the same edge it drops.
                if (!wr_q) begin
                    wr_d = 1'b1;
                end else if (Mem_Ack) begin
                    if (idx_q == LAST_IDX) begin
                        wr_d    = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (!rd_q) begin
                    rd_d = 1'b1;
                end else if (Mem_Ack) begin
                    buf_d[idx_q*DATA_W +: DATA_W] = Mem_Read_Data;
                    if (idx_q == LAST_IDX) begin
                        rd_d    = 1'b0;
                        state_d = S_COMMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_COMMIT: state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so Load_Proc is glitch-free
    // for the register file's edge-sensitive load.
    always_comb begin
        lp_d   = (state_d == S_COMMIT);
        done_d = (state_d == S_FINISH);
    end

    assign Mem_Addr       = base_q + ADDR_W'(idx_q);
    assign Mem_Write_Data = snap_q[idx_q*DATA_W +: DATA_W];
    assign Mem_Write      = wr_q;
    assign Mem_Read       = rd_q;
    assign Load_Data      = buf_q;
    assign Load_Proc      = lp_q;
    assign Done           = done_q;
    assign Busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_context_mover.sv
// Bench for reg_context_mover: behavioural memory with selectable ack
// pacing, a beat scoreboard filled when an operation is issued, and
// latency/strobe checks around Done and Load_Proc.
module tb_reg_context_mover;

    localparam int NR = 64;
    localparam int DW = 32;
    localparam int AW = 16;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             Save_Req = 1'b0;
    logic             Load_Req = 1'b0;
    logic [AW-1:0]    Ctx_Base = '0;
    logic [NR*DW-1:0] Save_Data = '0;
    logic [NR*DW-1:0] Load_Data;
    logic             Load_Proc;
    logic [AW-1:0]    Mem_Addr;
    logic [DW-1:0]    Mem_Write_Data;
    logic             Mem_Write;
    logic             Mem_Read;
    logic [DW-1:0]    Mem_Read_Data = '0;
    logic             Mem_Ack = 1'b0;
    logic             Busy;
    logic             Done;

    reg_context_mover #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .Clock(Clock), .Reset(Reset), .Save_Req(Save_Req), .Load_Req(Load_Req),
        .Ctx_Base(Ctx_Base), .Save_Data(Save_Data), .Load_Data(Load_Data),
        .Load_Proc(Load_Proc), .Mem_Addr(Mem_Addr), .Mem_Write_Data(Mem_Write_Data),
        .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .Mem_Read_Data(Mem_Read_Data),
        .Mem_Ack(Mem_Ack), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    beat_t sb[$];
    int total = 0;
    int bad   = 0;
    int mem_mode = 0;   // 0 manual ack, 1 ack tied high, 2 paced ack
    int period   = 1;
    int wcnt     = 0;
    logic man_ack = 1'b0;
    int rd_beats = 0;
    int wr_beats = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: decides the ack for the coming edge and scores every
    // beat that will complete on it.
    always @(negedge Clock) begin
        beat_t e;
        if (mem_mode == 0) Mem_Ack = man_ack;
        else if (mem_mode == 1) Mem_Ack = 1'b1;
        else if (Mem_Read || Mem_Write) begin
            if (wcnt == period - 1) begin Mem_Ack = 1'b1; wcnt = 0; end
            else begin Mem_Ack = 1'b0; wcnt++; end
        end else begin
            Mem_Ack = 1'b0;
            wcnt = 0;
        end
        Mem_Read_Data = 32'hB000_0000 + {16'h0, Mem_Addr};
        if (Reset && Mem_Ack && (Mem_Read || Mem_Write)) begin
            if (Mem_Read) rd_beats++; else wr_beats++;
            if (sb.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("beat_kind", {63'd0, Mem_Write}, {63'd0, e.wr});
                chk("beat_addr", {48'd0, Mem_Addr}, {48'd0, e.addr});
                if (Mem_Write) chk("beat_data", {32'd0, Mem_Write_Data}, {32'd0, e.data});
            end
        end
    end

    task automatic fill_save_data(input logic [31:0] seed);
        for (int i = 0; i < NR; i++) Save_Data[i*DW +: DW] = seed + i;
    endtask

    // Issue a request for one edge and push the beats it must produce.
    task automatic start_op(input bit sv, input bit ld, input logic [AW-1:0] base);
        @(negedge Clock);
        #1;
        Save_Req = sv;
        Load_Req = ld;
        Ctx_Base = base;
        for (int i = 0; i < NR; i++) begin
            beat_t e;
            e.wr   = sv;
            e.addr = base + AW'(i);
            e.data = sv ? Save_Data[i*DW +: DW] : '0;
            if (sv || ld) sb.push_back(e);
        end
        @(posedge Clock);
        #1;
        Save_Req = 1'b0;
        Load_Req = 1'b0;
        Ctx_Base = 16'hDEAD;
    endtask

    // Count cycles to Done; disturb Save_Data and pulse Load_Req mid-run.
    task automatic wait_done(output int cyc, output int lp_cyc, output int lp_cnt, output int busy_low);
        cyc = -1; lp_cyc = -1; lp_cnt = 0; busy_low = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge Clock);
            if (c == 10) begin Save_Data = ~Save_Data; Load_Req = 1'b1; end
            if (c == 11) Load_Req = 1'b0;
            if (Load_Proc) begin lp_cnt++; lp_cyc = c; end
            if (!Busy) busy_low++;
            if (Done) begin cyc = c; break; end
        end
        if (cyc < 0) chk("done_timeout", 64'd1, 64'd0);
        @(negedge Clock);
        chk("done_one_cycle", {63'd0, Done}, 64'd0);
        chk("idle_after_done", {63'd0, Busy}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_load_data(input logic [AW-1:0] base);
        int errs = 0;
        for (int i = 0; i < NR; i++)
            if (Load_Data[i*DW +: DW] !== 32'hB000_0000 + {16'h0, base + AW'(i)}) errs++;
        chk("load_data_words_wrong", 64'(errs), 64'd0);
        chk("load_data_word5", {32'd0, Load_Data[5*DW +: DW]}, {32'd0, 32'hB000_0000 + {16'h0, base + 16'd5}});
    endtask

    initial begin
        int cyc, lp_cyc, lp_cnt, busy_low, rb;

        // 1: reset values, then stray acks in IDLE
        repeat (3) @(negedge Clock);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_wr_rd", {62'd0, Mem_Write, Mem_Read}, 64'd0);
        chk("rst_lp_done", {62'd0, Load_Proc, Done}, 64'd0);
        chk("rst_addr", {48'd0, Mem_Addr}, 64'd0);
        chk("rst_wdata", {32'd0, Mem_Write_Data}, 64'd0);
        chk("rst_load_data", {63'd0, |Load_Data}, 64'd0);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            man_ack = i[0];
            @(negedge Clock);
        end
        man_ack = 1'b0;
        @(negedge Clock);
        chk("idle_ack_busy", {63'd0, Busy}, 64'd0);
        chk("idle_ack_req", {62'd0, Mem_Write, Mem_Read}, 64'd0);

        // 2: zero-wait save, Save_Data disturbed mid-save
        mem_mode = 1;
        fill_save_data(32'hA000_0000);
        start_op(1'b1, 1'b0, 16'h0100);
        wait_done(cyc, lp_cyc, lp_cnt, busy_low);
        chk("save_done_cycle", 64'(cyc), 64'd66);
        chk("save_no_load_proc", 64'(lp_cnt), 64'd0);
        chk("save_busy_held", 64'(busy_low), 64'd0);
        chk("save_writes", 64'(wr_beats), 64'd64);

        // 3: load with an ack every third cycle
        mem_mode = 2; period = 3;
        rb = rd_beats;
        start_op(1'b0, 1'b1, 16'h0200);
        wait_done(cyc, lp_cyc, lp_cnt, busy_low);
        chk("load_done_cycle", 64'(cyc), 64'd195);
        chk("load_proc_count", 64'(lp_cnt), 64'd1);
        chk("load_proc_before_done", 64'(lp_cyc), 64'(cyc - 1));
        chk("load_reads", 64'(rd_beats - rb), 64'd64);
        check_load_data(16'h0200);

        // 4: address wrap across 0xFFFF
        mem_mode = 1;
        fill_save_data(32'hC000_0000);
        start_op(1'b1, 1'b0, 16'hFFF0);
        wait_done(cyc, lp_cyc, lp_cnt, busy_low);
        chk("wrap_done_cycle", 64'(cyc), 64'd66);
        check_load_data(16'h0200);

        // 5: both requests together -> save only; mid-save load pulse ignored
        mem_mode = 2; period = 1;
        rb = rd_beats;
        fill_save_data(32'hD000_0000);
        start_op(1'b1, 1'b1, 16'h0400);
        wait_done(cyc, lp_cyc, lp_cnt, busy_low);
        chk("both_no_reads", 64'(rd_beats - rb), 64'd0);
        chk("both_busy_held", 64'(busy_low), 64'd0);
        chk("both_done_cycle", 64'(cyc), 64'd66);
        repeat (3) @(negedge Clock);
        chk("late_load_ignored", {63'd0, Busy}, 64'd0);

        // 6: reset after 20 read acks, then a clean load
        rb = rd_beats;
        start_op(1'b0, 1'b1, 16'h0500);
        for (int c = 0; c < 200 && (rd_beats - rb) < 20; c++) begin
            @(negedge Clock);
            #1;
        end
        chk("abort_reached_20", 64'(rd_beats - rb), 64'd20);
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_read_drop", {63'd0, Mem_Read}, 64'd0);
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        chk("abort_load_data", {63'd0, |Load_Data}, 64'd0);
        sb.delete();
        rb = rd_beats;
        lp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            if (Load_Proc) lp_cnt++;
        end
        chk("abort_no_load_proc", 64'(lp_cnt), 64'd0);
        chk("abort_no_beats", 64'(rd_beats - rb), 64'd0);
        Reset = 1'b1;
        start_op(1'b0, 1'b1, 16'h0300);
        wait_done(cyc, lp_cyc, lp_cnt, busy_low);
        chk("reload_done_cycle", 64'(cyc), 64'd67);
        chk("reload_proc_count", 64'(lp_cnt), 64'd1);
        check_load_data(16'h0300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_context_mover.md
Name: reg_context_mover

Overview:
- Context save/restore engine for process switching: moves the full 64-entry register bank snapshot between the register file and data memory.
- Save: captures the register file's flat 2048-bit Save_Data bus and writes it to memory, one 32-bit word per beat.
- Load: reads 64 words from memory into a shadow buffer, then drives the register file's Load_Data bus and pulses Load_Proc for one cycle.
- Sits between the register file and the data-memory port; the OS-level scheduler issues Save_Req/Load_Req.

Parameters:
- NUM_REGS, 64, number of registers moved; sets the Load_Data/Save_Data width to NUM_REGS*DATA_W.
- DATA_W, 32, register and memory word width.
- ADDR_W, 16, memory word-address width.

Ports:
- Clock  in  1  single system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low; clears all state when 0.
- Save_Req  in  1  start a save; sampled only in IDLE.
- Load_Req  in  1  start a load; sampled only in IDLE.
- Ctx_Base  in  ADDR_W  word address of the context area; latched at start.
- Save_Data  in  NUM_REGS*DATA_W  register bank snapshot; word i is bits [32i+31:32i].
- Load_Data  out  NUM_REGS*DATA_W  restored bank to the register file, same packing.
- Load_Proc  out  1  one-cycle strobe telling the register file to take Load_Data.
- Mem_Addr  out  ADDR_W  memory word address.
- Mem_Write_Data  out  DATA_W  write data.
- Mem_Write  out  1  write request.
- Mem_Read  out  1  read request.
- Mem_Read_Data  in  DATA_W  read data; valid in the Mem_Ack cycle.
- Mem_Ack  in  1  beat-complete acknowledge from memory.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values (Reset=0, effective immediately):
  - State is IDLE.
  - Index, Load_Data buffer, snapshot, Mem_Addr and Mem_Write_Data are all 0.
  - Mem_Write, Mem_Read, Load_Proc, Busy and Done are all 0.
- States: IDLE, SAVE, LOAD, COMMIT, FINISH.
- IDLE:
  - Save_Req=1 → SAVE. On the same edge: Save_Data is latched into the internal snapshot, Ctx_Base is latched, index is set to 0.
  - Load_Req=1 (and Save_Req=0) → LOAD. Ctx_Base is latched, index is set to 0.
  - Both requests high: save wins and the load is dropped; the requester must re-issue it.
  - Requests are ignored in every state other than IDLE.
- Beat handshake (applies in both SAVE and LOAD):
  - The request line is registered and rises the cycle after entering the state.
  - While a request is high, Mem_Addr and Mem_Write_Data are stable.
  - A beat completes on an edge where the request and Mem_Ack are both 1.
  - Mem_Ack is ignored while no request is high.
  - Non-final beat: index increments and the request stays high with the new address. Back-to-back beats are allowed, so a zero-wait memory gives 1 beat/cycle.
  - Final beat (index = NUM_REGS-1): the request drops on that edge.
- Address and data:
  - Mem_Addr = latched base + index, truncated to ADDR_W; it wraps modulo 2^ADDR_W.
  - In SAVE, Mem_Write_Data = snapshot word[index]. Later changes on Save_Data do not affect an in-progress save.
- SAVE: on the final-beat ack → FINISH.
- LOAD: each ack writes Mem_Read_Data into buffer word[index]; the final ack → COMMIT.
- COMMIT: lasts exactly 1 cycle.
  - Load_Proc=1 for that cycle only, then → FINISH.
  - Load_Proc comes straight from a flop with no combinational path, because the register file treats it as an asynchronous edge-sensitive load.
  - Load_Data is a registered buffer. It changes only on load beats, is stable during and after COMMIT, and holds its value until the next load.
- FINISH: Done=1 for 1 cycle, Busy still 1, then → IDLE.
- Latency with zero wait states:
  - Save: request edge to Done = 1 + 64 + 1 cycles.
  - Load: request edge to Done = 1 + 64 + 1 + 1 cycles.
  - Each memory wait cycle adds 1 cycle.
- Reset mid-operation:
  - Abort immediately; no further memory beats.
  - Load_Proc is not asserted; a partially filled buffer is cleared and never committed.
- Register 0 is moved like any other word; the register file enforces its zero value.

Test Plan:
1. Reset then idle: Reset=0 for 3 cycles, then Reset=1 → all outputs 0, Busy=0; Mem_Ack pulses with no request produce no state change.
2. Save, zero-wait memory (Mem_Ack tied 1): Save_Data word i = 32'hA000_0000+i, Ctx_Base=16'h0100 → 64 writes to addresses 0x0100..0x013F with data A000_0000..A000_003F in order; Done pulses at cycle 66; Save_Data changed mid-save does not alter the written data.
3. Load with wait states: memory returns 32'hB000_0000+addr and acks every 3rd cycle, Ctx_Base=16'h0200 → Load_Data word i = B000_0200+i; Load_Proc high exactly 1 cycle, immediately followed by a 1-cycle Done.
4. Address wrap: Ctx_Base=16'hFFF0, save → addresses FFF0..FFFF, then 0000..002F.
5. Simultaneous and late requests: Save_Req and Load_Req both high in IDLE → only writes occur; Load_Req pulsed mid-save is ignored and Busy stays 1 until Done.
6. Reset mid-load after 20 acks → Mem_Read drops asynchronously, Load_Proc stays 0, Load_Data=0; a following full load completes normally.
